// File: rtl/register_file_pkg.sv
// Shared CPU datapath definitions used by the register file and its clear sequencer.
// Contents: register-file sequencer state encoding, default datapath width.
// No ports; import with cpu_pkg::*.
package cpu_pkg;

   // Register-file sequencer state.
   typedef enum logic {
      RF_IDLE     = 1'b0,
      RF_CLEARING = 1'b1
   } rf_state_t;

   // Default datapath width for general-purpose registers.
   localparam int DATA_WIDTH = 16;

endpackage

// File: rtl/register_file_clear_sequencer.sv
// Self-timed clear sequencer: walks clr_ptr over every entry, one per cycle.
// Latency: busy rises the cycle after clear is sampled and stays high Depth cycles.
// Ports: clock, reset (async active-low), clear in; busy, clr_we, clr_addr out.
module rf_clear_sequencer
   import cpu_pkg::*;
#(
   parameter int Depth     = 8,
   parameter int AddrWidth = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   output logic                 busy,
   output logic                 clr_we,
   output logic [AddrWidth-1:0] clr_addr
);

   localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(Depth - 1);

   rf_state_t              state, state_nxt;
   logic [AddrWidth-1:0]   clr_ptr, clr_ptr_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= RF_IDLE;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      clr_we      = 1'b0;
      case (state)
         RF_IDLE: begin
            if (clear) begin
               state_nxt   = RF_CLEARING;
               clr_ptr_nxt = '0;
            end
         end
         RF_CLEARING: begin
            clr_we = 1'b1;
            if (clr_ptr == LastPtr) begin
               // Last entry written this edge; hand the bank back to users.
               state_nxt   = RF_IDLE;
               clr_ptr_nxt = '0;
            end else begin
               clr_ptr_nxt = clr_ptr + 1'b1;
            end
         end
         default: begin
            state_nxt   = RF_IDLE;
            clr_ptr_nxt = '0;
         end
      endcase
   end

   assign busy     = (state == RF_CLEARING);
   assign clr_addr = clr_ptr;

endmodule

// File: rtl/register_file.sv
// General-purpose register bank: one write port, two combinational read ports
// with write-first bypass, optional hard-wired zero entry, self-timed clear.
// Ports: clock, reset (async active-low), clear/busy, write_en/addr/data,
// read_a/b_addr in, read_a/b_data out (0-cycle read, bypass in the write cycle).
module register_file
   import cpu_pkg::*;
#(
   parameter  int               Width      = DATA_WIDTH,
   parameter  int               Depth      = 8,
   parameter  logic [Width-1:0] ResetValue = '0,
   parameter  bit               ZeroReg    = 1'b1,
   localparam int               AddrWidth  = $clog2(Depth)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   output logic                 busy,
   input  logic                 write_en,
   input  logic [AddrWidth-1:0] write_addr,
   input  logic [Width-1:0]     write_data,
   input  logic [AddrWidth-1:0] read_a_addr,
   input  logic [AddrWidth-1:0] read_b_addr,
   output logic [Width-1:0]     read_a_data,
   output logic [Width-1:0]     read_b_data
);

   // One extra bit so Depth itself is representable when Depth is a power of two.
   localparam logic [AddrWidth:0] DepthLim = Depth[AddrWidth:0];

   logic [Width-1:0]     mem [Depth];
   logic                 clr_we;
   logic [AddrWidth-1:0] clr_addr;
   logic                 write_ok;

   rf_clear_sequencer #(
      .Depth     (Depth),
      .AddrWidth (AddrWidth)
   ) u_clear_sequencer (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // User writes only land while idle, in range, and not on the zero entry.
   assign write_ok = write_en && !busy
                     && ({1'b0, write_addr} < DepthLim)
                     && !(ZeroReg && (write_addr == '0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= ResetValue;
         end
      end else if (clr_we) begin
         mem[clr_addr] <= ResetValue;
      end else if (write_ok) begin
         mem[write_addr] <= write_data;
      end
   end

   logic [AddrWidth-1:0] raddr [2];
   logic [Width-1:0]     rdata [2];

   assign raddr[0]    = read_a_addr;
   assign raddr[1]    = read_b_addr;
   assign read_a_data = rdata[0];
   assign read_b_data = rdata[1];

   for (genvar p = 0; p < 2; p++) begin : g_read
      always_comb begin
         rdata[p] = '0;
         if ({1'b0, raddr[p]} >= DepthLim) begin
            rdata[p] = '0;
         end else if (ZeroReg && (raddr[p] == '0)) begin
            rdata[p] = '0;
         end else if (write_ok && (write_addr == raddr[p])) begin
            rdata[p] = write_data;   // write-first bypass
         end else begin
            rdata[p] = mem[raddr[p]];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: three instances (Depth 8 zero-reg,
// Depth 8 no zero-reg, Depth 6 zero-reg) share stimulus; expectations are
// queued at drive time and compared on the falling edge by a monitor.
module tb_register_file;

   localparam logic [15:0] RV = 16'h00A5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        write_en = 1'b0;
   logic [2:0]  write_addr = '0;
   logic [15:0] write_data = '0;
   logic [2:0]  read_a_addr = '0;
   logic [2:0]  read_b_addr = '0;

   logic        busy0, busy1, busy2;
   logic [15:0] a0, b0, a1, b1, a2, b2;

   always #5 clock = ~clock;

   register_file #(.Width(16), .Depth(8), .ResetValue(RV), .ZeroReg(1'b1)) u_d0 (
      .clock(clock), .reset(reset), .clear(clear), .busy(busy0),
      .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .read_a_addr(read_a_addr), .read_b_addr(read_b_addr),
      .read_a_data(a0), .read_b_data(b0));

   register_file #(.Width(16), .Depth(8), .ResetValue(RV), .ZeroReg(1'b0)) u_d1 (
      .clock(clock), .reset(reset), .clear(clear), .busy(busy1),
      .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .read_a_addr(read_a_addr), .read_b_addr(read_b_addr),
      .read_a_data(a1), .read_b_data(b1));

   register_file #(.Width(16), .Depth(6), .ResetValue(RV), .ZeroReg(1'b1)) u_d2 (
      .clock(clock), .reset(reset), .clear(clear), .busy(busy2),
      .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .read_a_addr(read_a_addr), .read_b_addr(read_b_addr),
      .read_a_data(a2), .read_b_data(b2));

   // Selector codes for observed outputs.
   localparam int D0A = 0, D0B = 1, D1A = 2, D1B = 3, D2A = 4, D2B = 5,
                  BSY0 = 6, BSY1 = 7, BSY2 = 8;

   typedef struct {
      int          sel;
      logic [15:0] exp;
      string       name;
   } chk_t;

   chk_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         D0A:  return a0;
         D0B:  return b0;
         D1A:  return a1;
         D1B:  return b1;
         D2A:  return a2;
         D2B:  return b2;
         BSY0: return {15'd0, busy0};
         BSY1: return {15'd0, busy1};
         BSY2: return {15'd0, busy2};
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic expect_v(input int sel, input logic [15:0] v, input string n);
      chk_t c;
      c.sel = sel; c.exp = v; c.name = n;
      q.push_back(c);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Monitor: outputs are combinational, so every queued check is due on the
   // falling edge following the drive.
   always @(negedge clock) begin
      while (q.size() > 0) begin
         chk_t        c;
         logic [15:0] act;
         c   = q.pop_front();
         act = observe(c.sel);
         n_vec++;
         if (act !== c.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
         end
      end
   end

   initial begin
      @(posedge clock);
      #1;

      // Reset state across every address.
      for (int i = 0; i < 8; i++) begin
         read_a_addr = 3'(i);
         read_b_addr = 3'(i);
         expect_v(D0A, (i == 0) ? 16'h0000 : RV, $sformatf("rst_d0a_%0d", i));
         expect_v(D1B, RV, $sformatf("rst_d1b_%0d", i));
         expect_v(D2A, (i == 0 || i >= 6) ? 16'h0000 : RV, $sformatf("rst_d2a_%0d", i));
         expect_v(BSY0, 16'd0, "rst_busy0");
         cyc();
      end
      reset = 1'b1;
      cyc();

      // Bypass on write, then storage.
      write_en = 1'b1; write_addr = 3'd3; write_data = 16'h1234; read_a_addr = 3'd3;
      expect_v(D0A, 16'h1234, "bypass_d0");
      expect_v(D1A, 16'h1234, "bypass_d1");
      expect_v(D2A, 16'h1234, "bypass_d2");
      cyc();
      write_en = 1'b0;
      expect_v(D0A, 16'h1234, "stored_d0");
      expect_v(D2A, 16'h1234, "stored_d2");
      cyc();

      // Zero entry.
      write_en = 1'b1; write_addr = 3'd0; write_data = 16'hFFFF; read_a_addr = 3'd0;
      expect_v(D0A, 16'h0000, "zero_byp_d0");
      expect_v(D1A, 16'hFFFF, "zero_byp_d1");
      expect_v(D2A, 16'h0000, "zero_byp_d2");
      cyc();
      write_en = 1'b0;
      expect_v(D0A, 16'h0000, "zero_st_d0");
      expect_v(D1A, 16'hFFFF, "zero_st_d1");
      cyc();

      // Out-of-range on Depth 6.
      write_en = 1'b1; write_addr = 3'd7; write_data = 16'h7777;
      read_a_addr = 3'd6; read_b_addr = 3'd7;
      expect_v(D2A, 16'h0000, "oor_d2a");
      expect_v(D2B, 16'h0000, "oor_d2b");
      expect_v(D0B, 16'h7777, "oor_d0b_byp");
      cyc();
      write_en = 1'b0; read_a_addr = 3'd7;
      expect_v(D2A, 16'h0000, "oor_d2a_st");
      expect_v(D0A, 16'h7777, "oor_d0a_st");
      cyc();

      // Fill with distinct values.
      for (int i = 0; i < 8; i++) begin
         write_en = 1'b1; write_addr = 3'(i); write_data = 16'h1000 + 16'(i);
         read_a_addr = 3'(i);
         expect_v(D1A, 16'h1000 + 16'(i), $sformatf("fill_d1a_%0d", i));
         cyc();
      end

      // Clear with BEEF writes hammering entry 2 while busy.
      write_en = 1'b0; clear = 1'b1; read_a_addr = 3'd2; read_b_addr = 3'd5;
      expect_v(BSY0, 16'd0, "clr_req_busy0");
      expect_v(D0B, 16'h1005, "clr_req_d0b");
      expect_v(D2B, 16'h1005, "clr_req_d2b");
      cyc();
      clear = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         write_en = 1'b1; write_addr = 3'd2; write_data = 16'hBEEF;
         expect_v(BSY0, 16'd1, $sformatf("clr_busy0_%0d", k));
         expect_v(BSY1, 16'd1, $sformatf("clr_busy1_%0d", k));
         expect_v(BSY2, (k <= 6) ? 16'd1 : 16'd0, $sformatf("clr_busy2_%0d", k));
         expect_v(D0A, (k <= 3) ? 16'h1002 : RV, $sformatf("clr_d0a_%0d", k));
         expect_v(D1A, (k <= 3) ? 16'h1002 : RV, $sformatf("clr_d1a_%0d", k));
         expect_v(D0B, (k <= 6) ? 16'h1005 : RV, $sformatf("clr_d0b_%0d", k));
         expect_v(D2A, (k <= 3) ? 16'h1002 : ((k <= 6) ? RV : 16'hBEEF),
                  $sformatf("clr_d2a_%0d", k));
         expect_v(D2B, (k <= 6) ? 16'h1005 : RV, $sformatf("clr_d2b_%0d", k));
         cyc();
      end
      // Busy dropped: first write accepted, BEEF left no trace on Depth 8.
      write_en = 1'b1; write_addr = 3'd4; write_data = 16'h4444; read_b_addr = 3'd4;
      expect_v(BSY0, 16'd0, "post_busy0");
      expect_v(D0A, RV, "post_d0a");
      expect_v(D1A, RV, "post_d1a");
      expect_v(D2A, 16'hBEEF, "post_d2a");
      expect_v(D0B, 16'h4444, "post_d0b_byp");
      cyc();
      write_en = 1'b0;
      expect_v(D0B, 16'h4444, "post_d0b_st");
      cyc();

      // Reset in the middle of a clear.
      clear = 1'b1;
      expect_v(BSY0, 16'd0, "mid_req_busy0");
      cyc();
      clear = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         expect_v(BSY0, 16'd1, $sformatf("mid_busy0_%0d", k));
         cyc();
      end
      reset = 1'b0; read_a_addr = 3'd4; read_b_addr = 3'd2;
      expect_v(BSY0, 16'd0, "mid_rst_busy0");
      expect_v(BSY2, 16'd0, "mid_rst_busy2");
      expect_v(D0A, RV, "mid_rst_d0a");
      expect_v(D2B, RV, "mid_rst_d2b");
      cyc();
      reset = 1'b1;
      cyc();
      clear = 1'b1;
      expect_v(BSY0, 16'd0, "re_req_busy0");
      cyc();
      clear = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         expect_v(BSY0, (k <= 8) ? 16'd1 : 16'd0, $sformatf("re_busy0_%0d", k));
         cyc();
      end

      @(negedge clock);
      #1;
      if (q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register bank: one write port, two independent combinational read ports with write-first bypass, optional hard-wired zero entry, and a self-timed clear sequencer. Next generation of the single-entry clock-enabled register. Sits in the CPU datapath as the general-purpose register store, between instruction decode (addresses) and the ALU operand/writeback buses.

## Interface
- `Width`, 16, data width of every entry (1..64).
- `Depth`, 8, number of entries (2..256, need not be a power of two).
- `ResetValue`, 0, value loaded into every entry by reset and by the clear sequence.
- `ZeroReg`, 1, when 1 entry 0 always reads 0 and ignores writes.
- `AddrWidth`, derived `$clog2(Depth)`, not overridable.

- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; one clock, reset is asynchronous and active-low.
- `clear` in 1: single-cycle request to start the clear sequence.
- `busy` out 1: high while the clear sequence runs.
- `write_en` in 1: write strobe.
- `write_addr` in AddrWidth: write entry index.
- `write_data` in Width: write data.
- `read_a_addr`, `read_b_addr` in AddrWidth: read port indices.
- `read_a_data`, `read_b_data` out Width: read port data (combinational).

## Operation
- Storage: Depth x Width flops. FSM states IDLE, CLEARING; clear pointer `clr_ptr` (AddrWidth).
- Reset asserted (reset=0): every entry = ResetValue, state IDLE, clr_ptr = 0, busy = 0. Takes effect immediately, including mid-clear.
- IDLE, write_en=1, write_addr < Depth, not (ZeroReg and write_addr==0): entry updated at next edge. Otherwise write dropped silently.
- Read port X: if addr >= Depth -> 0; else if ZeroReg and addr==0 -> 0; else if IDLE and write_en and write_addr==addr (and write accepted) -> write_data (bypass); else stored entry. Both ports may read the same address.
- IDLE and clear=1 -> CLEARING, clr_ptr = 0 at the same edge; a write presented in that same cycle is accepted (write wins its entry for one cycle, then cleared in sequence).
- CLEARING: each edge writes ResetValue to entry clr_ptr, clr_ptr increments; after entry Depth-1 is written -> IDLE, clr_ptr = 0.
- CLEARING: write_en ignored (no storage update, no bypass); clear ignored; reads return current storage (partially cleared).

## Timing
- Read latency: 0 cycles (combinational from addr and storage/bypass).
- Write latency: visible via bypass in the write cycle, from storage the cycle after.
- busy: combinational decode of state == CLEARING; rises the cycle after clear sampled, stays high exactly Depth cycles.
- Clear duration: Depth cycles; first write accepted again in the cycle busy drops.
- Reset values: busy=0; read data = ResetValue for any in-range non-zero-reg address, 0 otherwise.

## Structure
- Shared package `cpu_pkg`: state enum `rf_state_t` {RF_IDLE, RF_CLEARING}; default Width constant for datapath.
- Sub-module `rf_clear_sequencer`: FSM + clr_ptr, outputs busy, clr_we, clr_addr. Storage, write arbitration and read muxes stay in `register_file`.
- Write arbitration: clr_we has priority; user write enabled only when !busy.

## Test plan
- Reset then read all addresses with ResetValue=16'h00A5, Depth=8, ZeroReg=1 -> entry 0 reads 0, entries 1..7 read 00A5, busy=0.
- Write 16'h1234 to entry 3 while read_a_addr=3 -> read_a_data=1234 same cycle (bypass), still 1234 next cycle with write_en=0.
- ZeroReg=1, write 16'hFFFF to entry 0 -> read 0; ZeroReg=0 same -> FFFF.
- Fill entries with distinct values, pulse clear -> busy high exactly 8 cycles; read_b_addr=5 shows old value until cycle 6 of busy, then ResetValue; writes of 16'hBEEF during busy leave no trace.
- Depth=6: write to address 7 and read address 6 -> write dropped, read returns 0.
- Pull reset low mid-clear (cycle 3 of 8) -> busy drops immediately, all entries ResetValue, next clear pulse runs full 8 cycles.
